// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between the instruction-fetch
// requester (if_*) and the load/store requester (dm_*). One transaction is outstanding
// at a time. Misaligned requests are answered with an error and never reach memory.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate the grant on a tie; when it is
// undefined the data port wins every tie.
module mem_port_arbiter #(
    parameter int XLEN        = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [XLEN-1:0] if_req_addr,
    output logic            if_rsp_valid,
    output logic [XLEN-1:0] if_rsp_data,
    output logic            if_rsp_err,
    input  logic            dm_req_valid,
    output logic            dm_req_ready,
    input  logic            dm_req_we,
    input  logic [XLEN-1:0] dm_req_addr,
    input  logic [XLEN-1:0] dm_req_wdata,
    output logic            dm_rsp_valid,
    output logic [XLEN-1:0] dm_rsp_rdata,
    output logic            dm_rsp_err,
    output logic            mem_en,
    output logic            mem_write_enable,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_write_data,
    input  logic [XLEN-1:0] mem_read_data
);

    localparam int OFF_W = $clog2(XLEN / 8);
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;
    typedef enum logic {PORT_IF = 1'b0, PORT_DM = 1'b1} port_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] lat_cnt;
    port_t            owner;
    logic             we_q;
    logic             tie_to_dm;
    logic             handshake;
    logic             misaligned;
    logic [XLEN-1:0]  req_addr;

`ifdef ARB_ROUND_ROBIN_EN
    port_t last_grant;

    // On a tie the port that was not granted last wins.
    assign tie_to_dm = (last_grant == PORT_IF);

    // Remember which port completed the most recent handshake, error responses included.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= PORT_IF;
        end else if (handshake) begin
            last_grant <= dm_req_ready ? PORT_DM : PORT_IF;
        end
    end
`else
    assign tie_to_dm = 1'b1;
`endif

    // Grant one requester, only while idle; a lone requester always wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        if_req_ready = 1'b0;
        dm_req_ready = 1'b0;
        if (state == IDLE) begin
            if (if_req_valid && dm_req_valid) begin
                if (tie_to_dm) dm_req_ready = 1'b1;
                else           if_req_ready = 1'b1;
            end else begin
                if_req_ready = if_req_valid;
                dm_req_ready = dm_req_valid;
            end
        end
    end

    assign handshake  = (if_req_valid && if_req_ready) || (dm_req_valid && dm_req_ready);
    assign req_addr   = dm_req_ready ? dm_req_addr : if_req_addr;
    assign misaligned = |req_addr[OFF_W-1:0];

    assign mem_en           = (state == ACCESS);
    assign mem_write_enable = mem_en && we_q;

    // Next-state logic: one strobe cycle, then wait out the fixed memory latency.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (handshake && !misaligned) state_next = ACCESS;
            ACCESS:  state_next = WAIT;
            WAIT:    if (lat_cnt == CNT_W'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register and latency counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state   <= IDLE;
            lat_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ACCESS) begin
                lat_cnt <= CNT_W'(MEM_LATENCY);
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
        end
    end

    // Capture the accepted request, and build the one-cycle response for its owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner          <= PORT_IF;
            we_q           <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            if_rsp_valid   <= 1'b0;
            if_rsp_data    <= '0;
            if_rsp_err     <= 1'b0;
            dm_rsp_valid   <= 1'b0;
            dm_rsp_rdata   <= '0;
            dm_rsp_err     <= 1'b0;
        end else begin
            if_rsp_valid <= 1'b0;
            dm_rsp_valid <= 1'b0;

            if (handshake) begin
                if (misaligned) begin
                    // Answer immediately with an error; memory is never touched.
                    if (dm_req_ready) begin
                        dm_rsp_valid <= 1'b1;
                        dm_rsp_err   <= 1'b1;
                        dm_rsp_rdata <= '0;
                    end else begin
                        if_rsp_valid <= 1'b1;
                        if_rsp_err   <= 1'b1;
                        if_rsp_data  <= '0;
                    end
                end else begin
                    owner       <= dm_req_ready ? PORT_DM : PORT_IF;
                    we_q        <= dm_req_ready && dm_req_we;
                    mem_address <= req_addr;
                    if (dm_req_ready) mem_write_data <= dm_req_wdata;
                end
            end

            // Last wait cycle: read data is valid now, so hand it to the owner.
            if (state == WAIT && lat_cnt == CNT_W'(1)) begin
                if (owner == PORT_DM) begin
                    dm_rsp_valid <= 1'b1;
                    dm_rsp_err   <= 1'b0;
                    dm_rsp_rdata <= we_q ? '0 : mem_read_data;
                end else begin
                    if_rsp_valid <= 1'b1;
                    if_rsp_err   <= 1'b0;
                    if_rsp_data  <= mem_read_data;
                end
            end
        end
    end

endmodule
